// File: rtl/gray_sched_pkg.sv
// Shared definitions for the Gray step scheduler: FSM encoding, default sizes
// and the binary-to-Gray helper.
package gray_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_CNT_W = 4;

  // Operates on a 32-bit container; callers slice back to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_updown_core.sv
// Modulo up/down binary register with Gray view and a registered wrap pulse.
module gray_updown_core
  import gray_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clck,
  input  logic             rset_n,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV = '1;

  always_ff @(posedge clck or negedge rset_n) begin
    if (!rset_n) begin
      bin  <= '0;
      wrap <= 1'b0;
    end else begin
      // Wrap is flagged for the cycle following the crossing step.
      wrap <= en && (dir ? (bin == MAXV) : (bin == '0));
      if (en) bin <= dir ? bin + WIDTH'(1) : bin - WIDTH'(1);
    end
  end

  assign gray = WIDTH'(bin2gray(32'(bin)));

endmodule

// File: rtl/gray_step_sched.sv
// Command-driven step sequencer: accepts (dir, steps), walks the Gray counter
// one position per cycle with pause/abort, then pulses done.
module gray_step_sched
  import gray_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clck,
  input  logic             rset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             wrap
);

  state_t           state, state_nxt;
  logic             dir_q, dir_nxt;
  logic [CNT_W-1:0] rem_q, rem_nxt;
  logic             abt_q, abt_nxt;
  logic             step_en;

  always_ff @(posedge clck or negedge rset_n) begin
    if (!rset_n) begin
      state <= IDLE;
      dir_q <= 1'b0;
      rem_q <= '0;
      abt_q <= 1'b0;
    end else begin
      state <= state_nxt;
      dir_q <= dir_nxt;
      rem_q <= rem_nxt;
      abt_q <= abt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir_q;
    rem_nxt   = rem_q;
    abt_nxt   = abt_q;
    step_en   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          dir_nxt   = cmd_dir;
          rem_nxt   = cmd_steps;
          abt_nxt   = 1'b0;
          state_nxt = (cmd_steps == '0) ? DONE : STEP;
        end
      end
      STEP: begin
        // Abort outranks both pause and the final step.
        if (abort) begin
          abt_nxt   = 1'b1;
          state_nxt = DONE;
        end else if (!pause) begin
          step_en = 1'b1;
          rem_nxt = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == STEP);
  assign done      = (state == DONE);
  assign aborted   = done & abt_q;

  gray_updown_core #(.WIDTH(WIDTH)) u_core (
    .clck  (clck),
    .rset_n(rset_n),
    .en    (step_en),
    .dir   (dir_q),
    .bin   (bin_out),
    .gray  (gray_out),
    .wrap  (wrap)
  );

endmodule

// File: tb/tb_gray_step_sched.sv
// Randomized command-level bench for gray_step_sched with an arithmetic
// position model.
module tb_gray_step_sched;

  localparam int N = 8;

  logic       clck = 1'b0;
  logic       rset_n;
  logic       cmd_valid, cmd_ready, cmd_dir;
  logic [3:0] cmd_steps;
  logic       pause, abort;
  logic [2:0] gray_out, bin_out;
  logic       busy, done, aborted, wrap;

  int n_tests = 0;
  int n_fail  = 0;
  int pos     = 0;

  always #5 clck = ~clck;

  gray_step_sched dut (
    .clck     (clck),
    .rset_n   (rset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_steps(cmd_steps),
    .pause    (pause),
    .abort    (abort),
    .gray_out (gray_out),
    .bin_out  (bin_out),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .wrap     (wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int gray_of(input int p);
    return p ^ (p / 2);
  endfunction

  task automatic check_pos(input string tag);
    check({tag, ".bin"}, 32'(bin_out), pos);
    check({tag, ".gray"}, 32'(gray_out), gray_of(pos));
  endtask

  // One full command: accept, steps with optional pause/abort, done, back to idle.
  task automatic run_cmd(input bit dir, input int steps, input int pause_after,
                         input int pause_len, input int abort_at, input bit rand_pause,
                         input bit keep_valid);
    int  left = steps, taken = 0, paused = 0;
    bit  exp_wrap = 0, ab = 0, pa;
    @(negedge clck);
    check("idle.ready", 32'(cmd_ready), 1);
    check("idle.done", 32'(done), 0);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_steps = 4'(steps);
    @(posedge clck); #1;
    if (!keep_valid) cmd_valid = 1'b0;
    cmd_dir = ~dir; cmd_steps = 4'($urandom);
    if (steps != 0) begin
      forever begin
        @(negedge clck);
        check("step.busy", 32'(busy), 1);
        check("step.ready", 32'(cmd_ready), 0);
        check("step.done", 32'(done), 0);
        check("step.wrap", 32'(wrap), 32'(exp_wrap));
        check_pos("step");
        ab = (taken == abort_at);
        pa = 0;
        if (taken == pause_after && paused < pause_len) begin pa = 1; paused++; end
        else if (rand_pause) pa = ($urandom_range(0, 3) == 0);
        abort = ab; pause = pa;
        @(posedge clck); #1;
        if (ab) begin exp_wrap = 0; break; end
        if (pa) exp_wrap = 0;
        else begin
          exp_wrap = dir ? (pos == N - 1) : (pos == 0);
          pos = dir ? (pos + 1) % N : (pos + N - 1) % N;
          taken++; left--;
          if (left == 0) break;
        end
      end
    end
    // Pause/abort outside STEP must be ignored.
    abort = $urandom_range(0, 1); pause = $urandom_range(0, 1);
    @(negedge clck);
    check("done.pulse", 32'(done), 1);
    check("done.aborted", 32'(aborted), 32'(ab));
    check("done.busy", 32'(busy), 0);
    check("done.ready", 32'(cmd_ready), 0);
    check("done.wrap", 32'(wrap), 32'(exp_wrap));
    check_pos("done");
    cmd_valid = 1'b0;
    @(posedge clck); #1;
    abort = 1'b0; pause = 1'b0;
    @(negedge clck);
    check("post.ready", 32'(cmd_ready), 1);
    check("post.done", 32'(done), 0);
    check("post.wrap", 32'(wrap), 0);
    check_pos("post");
  endtask

  initial begin
    bit hit;
    rset_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0;
    pause = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clck);
    #1 rset_n = 1'b1;
    @(negedge clck);
    check("rst.bin", 32'(bin_out), 0);
    check("rst.gray", 32'(gray_out), 0);
    check("rst.ready", 32'(cmd_ready), 1);
    check("rst.done", 32'(done), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.wrap", 32'(wrap), 0);

    run_cmd(1, 5, -1, 0, -1, 0, 0);   // up 5 from 0
    run_cmd(0, 4, -1, 0, -1, 0, 0);   // down to 1
    run_cmd(0, 3, -1, 0, -1, 0, 0);   // 0,7,6 with wrap
    run_cmd(1, 0, -1, 0, -1, 0, 0);   // zero steps
    run_cmd(1, 3, -1, 0, -1, 0, 1);   // cmd_valid held through command
    run_cmd(1, 15, -1, 0, -1, 0, 0);  // maximum count

    // Async reset mid-command at bin 3.
    @(negedge clck);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 4'd12;
    @(posedge clck); #1 cmd_valid = 1'b0;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clck);
      if (bin_out == 3'd3) hit = 1;
    end
    check("arst.reach3", 32'(hit), 1);
    @(posedge clck); #2;
    rset_n = 1'b0;
    #1;
    check("arst.bin", 32'(bin_out), 0);
    check("arst.gray", 32'(gray_out), 0);
    check("arst.busy", 32'(busy), 0);
    check("arst.done", 32'(done), 0);
    check("arst.wrap", 32'(wrap), 0);
    @(negedge clck); rset_n = 1'b1;
    pos = 0;
    hit = 0;
    repeat (4) begin
      @(negedge clck);
      if (done) hit = 1;
      check_pos("arst.hold");
    end
    check("arst.nodone", 32'(hit), 0);
    check("arst.ready", 32'(cmd_ready), 1);

    run_cmd(1, 6, 2, 2, 4, 0, 0);     // pause after step 2, abort after step 4
    run_cmd(0, 5, -1, 0, 0, 0, 0);    // immediate abort, no step

    for (int k = 0; k < 40; k++)
      run_cmd($urandom_range(0, 1), $urandom_range(0, 15), -1, 0,
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1,
              1, $urandom_range(0, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
